// File: rtl/mem_unit.sv
// Load/store unit: holds one memory request until acknowledged or timed out,
// then pulses done. Non-memory opcodes pass straight through to done.
module mem_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] address,
  input  logic [15:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_we_next;
  logic [15:0]      mem_addr_next;
  logic [15:0]      mem_wdata_next;
  logic [15:0]      read_data_next;
  logic             error_next;
  logic             mem_req_next;
  logic             busy_next;
  logic             done_next;
  logic             is_mem_op;

  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Next-state and next-register values; status outputs follow the next state
  // so they are registered yet aligned with the state they describe.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    read_data_next = read_data;
    error_next     = error;

    case (state)
      IDLE: begin
        if (start) begin
          if (is_mem_op) begin
            mem_we_next    = (opcode == OP_STORE);
            mem_addr_next  = address;
            mem_wdata_next = store_data;
            error_next     = 1'b0;
            wait_cnt_next  = '0;
            state_next     = ACCESS;
          end else begin
            state_next = DONE;
          end
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle still completes normally.
        if (mem_ack) begin
          if (!mem_we) begin
            read_data_next = mem_rdata;
          end
          state_next = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          error_next = 1'b1;
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    mem_req_next = (state_next == ACCESS);
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      read_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      read_data <= read_data_next;
      busy      <= busy_next;
      done      <= done_next;
      error     <= error_next;
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit (TIMEOUT=4): directed scenarios followed by random
// transactions checked against a transaction-level reference model.
module tb_mem_unit;

  localparam int unsigned T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] address;
  logic [15:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] read_data;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  // Reference model state: what read_data and error should hold between ops.
  logic [15:0] exp_rdata;
  logic        exp_err;

  mem_unit #(.TIMEOUT(T)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .address    (address),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_req"}, mem_req, 1'b0);
    chk1({tag, "_we"}, mem_we, 1'b0);
    chk16({tag, "_addr"}, mem_addr, 16'h0000);
    chk16({tag, "_wdata"}, mem_wdata, 16'h0000);
    chk16({tag, "_rdata"}, read_data, 16'h0000);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_error"}, error, 1'b0);
  endtask

  // One transaction. ack_at = ACCESS cycle (1-based) carrying mem_ack, 0 = never.
  // poke pulses start with a different address in ACCESS cycle 2.
  task automatic run_op(input logic [3:0] op, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int ack_at, input bit poke);
    bit is_mem;
    bit is_st;
    bit acked;
    int n_acc;
    is_mem = (op == 4'hC) || (op == 4'hD);
    is_st  = (op == 4'hD);
    acked  = (ack_at >= 1) && (ack_at <= int'(T));
    n_acc  = acked ? ack_at : int'(T);

    chk1("pre_busy", busy, 1'b0);
    start = 1'b1; opcode = op; address = addr; store_data = wdata;
    tick;
    start = 1'b0; opcode = 4'($urandom); address = 16'($urandom); store_data = 16'($urandom);

    if (is_mem) begin
      for (int n = 1; n <= n_acc; n++) begin
        chk1("acc_req", mem_req, 1'b1);
        chk1("acc_we", mem_we, is_st);
        chk16("acc_addr", mem_addr, addr);
        if (is_st) chk16("acc_wdata", mem_wdata, wdata);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_done", done, 1'b0);
        chk1("acc_err_clr", error, 1'b0);
        mem_ack   = (n == ack_at);
        mem_rdata = (n == ack_at) ? rdata : 16'($urandom);
        if (poke && n == 2) begin
          start = 1'b1; opcode = 4'hC; address = ~addr;
        end
        tick;
        mem_ack = 1'b0;
        start   = 1'b0;
      end
      if (acked) begin
        if (!is_st) exp_rdata = rdata;
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end

    chk1("done_pulse", done, 1'b1);
    chk1("done_req", mem_req, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk16("done_rdata", read_data, exp_rdata);
    chk1("done_error", error, exp_err);
    if (poke) chk16("poke_addr", mem_addr, addr);
    tick;
    chk1("post_done", done, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk1("post_req", mem_req, 1'b0);

    // Stray ack while idle must be ignored.
    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    tick;
    mem_ack = 1'b0;
    chk16("stray_rdata", read_data, exp_rdata);
    chk1("stray_error", error, exp_err);
    chk1("stray_busy", busy, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    int v;
    reset = 1'b1; start = 1'b0; opcode = 4'h0; address = 16'h0; store_data = 16'h0;
    mem_rdata = 16'h0; mem_ack = 1'b0;
    exp_rdata = 16'h0; exp_err = 1'b0;
    #3;
    chk_all_zero("reset");
    tick; tick;
    reset = 1'b0;

    run_op(4'hC, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b0);  // load, ack after 3
    run_op(4'hD, 16'h1234, 16'hA5A5, 16'h5555, 1, 1'b0);  // store, immediate ack
    run_op(4'h0, 16'h0777, 16'h1111, 16'h2222, 0, 1'b0);  // non-memory
    run_op(4'hC, 16'h0100, 16'h0000, 16'hDEAD, 0, 1'b0);  // timeout
    run_op(4'h7, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);  // non-mem keeps error
    run_op(4'hC, 16'h0101, 16'h0000, 16'hCAFE, 2, 1'b0);  // load clears error
    run_op(4'hC, 16'h0102, 16'h0000, 16'h1357, 4, 1'b0);  // ack on timeout cycle
    run_op(4'hC, 16'h0200, 16'h0000, 16'h2468, 3, 1'b1);  // start during ACCESS

    // Reset in ACCESS cycle 2: everything drops at once, no done pulse.
    start = 1'b1; opcode = 4'hC; address = 16'h0300;
    tick;
    start = 1'b0;
    tick;
    chk1("pre_rst_req", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick;
    chk1("rst_no_done", done, 1'b0);
    tick;
    exp_rdata = 16'h0; exp_err = 1'b0;
    reset = 1'b0;
    run_op(4'hC, 16'h0055, 16'h0000, 16'h9ABC, 1, 1'b0);  // first start after reset

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 3: op = 4'hC;
        1:    op = 4'hD;
        default: begin
          v  = int'($urandom_range(0, 13));
          op = (v < 12) ? 4'(v) : 4'(v + 2);
        end
      endcase
      run_op(op, 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 6)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
